// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and an iterative restoring divider.
// Single-cycle ops register their result on accept; DIV/REM iterate one quotient bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  output logic             error_flag,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_REM  = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               sc_err;
  logic               start_div;

  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic [SHW-1:0]     cnt_q;
  logic               is_rem_q;
  logic [WIDTH-1:0]   part;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   div_res;

  assign in_ready = (state == IDLE);

  assign sum  = a + b;
  assign diff = a - b;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign start_div = ((op_code == OP_DIV) || (op_code == OP_REM)) && (b != '0);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    case (op_code)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = a << b[SHW-1:0];
      OP_SRL:  sc_res = a >> b[SHW-1:0];
      OP_SRA:  sc_res = $signed(a) >>> b[SHW-1:0];
      OP_MULT: begin
        sc_res = prod[WIDTH-1:0];
        sc_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      // Only reached with b == 0; non-zero divisors go through DIV_RUN.
      OP_DIV: begin
        sc_res = '1;
        sc_err = 1'b1;
      end
      OP_REM: begin
        sc_res = a;
        sc_err = 1'b1;
      end
      default: begin
        sc_res = '0;
        sc_err = 1'b1;
      end
    endcase
  end

  // The partial remainder is kept unrestored (may be negative) and fixed up at the
  // start of the next step, so one subtractor decides each quotient bit.
  assign part    = rem_q[WIDTH-1:0] + (rem_q[WIDTH] ? dvsr_q : {WIDTH{1'b0}});
  assign shifted = {part, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign div_res = is_rem_q ? (trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0])
                            : quo_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      result        <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      overflow_flag <= 1'b0;
      error_flag    <= 1'b0;
      busy          <= 1'b0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      cnt_q         <= '0;
      is_rem_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_div) begin
              state    <= DIV_RUN;
              busy     <= 1'b1;
              cnt_q    <= SHW'(WIDTH - 1);
              rem_q    <= '0;
              quo_q    <= a;
              dvsr_q   <= b;
              is_rem_q <= (op_code == OP_REM);
            end else begin
              state         <= DONE;
              out_valid     <= 1'b1;
              result        <= sc_res;
              zero_flag     <= (sc_res == '0);
              negative_flag <= sc_res[WIDTH-1];
              overflow_flag <= sc_ovf;
              error_flag    <= sc_err;
            end
          end
        end
        DIV_RUN: begin
          rem_q <= trial;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state         <= DONE;
            busy          <= 1'b0;
            out_valid     <= 1'b1;
            result        <= div_res;
            zero_flag     <= (div_res == '0);
            negative_flag <= div_res[WIDTH-1];
            overflow_flag <= 1'b0;
            error_flag    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model plus a per-cycle output checker,
// driven by directed vectors with hand-computed literal expectations.
module tb_alu_seq;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op_code;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        negative_flag;
  logic        overflow_flag;
  logic        error_flag;
  logic        busy;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_code(op_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .zero_flag(zero_flag), .negative_flag(negative_flag),
    .overflow_flag(overflow_flag), .error_flag(error_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        o;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur   = 1'b0;
  bit   hs_pending = 1'b0;
  int   checks     = 0;
  int   failures   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t           e;
    longint         s;
    longint unsigned p;
    e = '0;
    case (op)
      4'd0: begin
        s   = longint'($signed(x)) + longint'($signed(y));
        e.r = x + y;
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'd1: begin
        s   = longint'($signed(x)) - longint'($signed(y));
        e.r = x - y;
        e.o = (s > SMAX) || (s < SMIN);
      end
      4'd2: e.r = x & y;
      4'd3: e.r = x | y;
      4'd4: e.r = x ^ y;
      4'd5: e.r = x << y[4:0];
      4'd6: e.r = x >> y[4:0];
      4'd7: e.r = $signed(x) >>> y[4:0];
      4'd8: begin
        p   = {32'd0, x} * {32'd0, y};
        e.r = p[31:0];
        e.o = (p[63:32] != 32'd0);
      end
      4'd9: begin
        e.e = (y == 32'd0);
        e.r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      end
      4'd10: begin
        e.e = (y == 32'd0);
        e.r = (y == 32'd0) ? x : x % y;
      end
      default: begin
        e.r = 32'd0;
        e.e = 1'b1;
      end
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_pending = 1'b1;
  end

  // Compare process: every cycle out_valid is high, outputs must match the model.
  always @(negedge clk) begin
    if (rst) begin
      have_cur   = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hs_pending) begin
        have_cur   = 1'b0;
        hs_pending = 1'b0;
      end
      if (out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_out_valid: out_valid=1 with no accepted op at %0t", $time);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          have_cur = 1'b1;
        end
        chk("mon_result",   result,        cur.r);
        chk("mon_zero",     zero_flag,     cur.z);
        chk("mon_negative", negative_flag, cur.n);
        chk("mon_overflow", overflow_flag, cur.o);
        chk("mon_error",    error_flag,    cur.e);
        chk("mon_in_ready_done", in_ready, 1'b0);
      end
    end
  end

  task automatic accept(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    op_code  = op;
    a        = x;
    b        = y;
    @(posedge clk);
    exp_q.push_back(model(op, x, y));
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op_code  = 4'($urandom);
  endtask

  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (out_valid) break;
    end
    chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [3:0]  tv_op [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10};
  logic [31:0] tv_a  [8] = '{32'h8000_0000, 32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555,
                             32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1000};
  logic [31:0] tv_b  [8] = '{32'd1, 32'h0FF0_FF00, 32'h1000_0010, 32'hFFFF_0000,
                             32'h0000_0024, 32'h0000_001F, 32'd3, 32'd7};

  int lat;
  int bc;
  int seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op_code   = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_result",    result,    32'd0);
    chk("rst_flags",     {zero_flag, negative_flag, overflow_flag, error_flag}, 4'b0000);
    chk("rst_busy",      busy,      1'b0);
    rst = 1'b0;

    // Signed overflow on ADD.
    accept(4'd0, 32'h7FFF_FFFF, 32'd1);
    wait_valid(lat, bc);
    chk("add_latency",  lat,           1);
    chk("add_result",   result,        32'h8000_0000);
    chk("add_overflow", overflow_flag, 1'b1);
    chk("add_negative", negative_flag, 1'b1);
    chk("add_zero",     zero_flag,     1'b0);
    release_out();

    // Iterative divide and remainder.
    accept(4'd9, 32'd100, 32'd7);
    wait_valid(lat, bc);
    chk("div_latency", lat,        33);
    chk("div_busy",    bc,         32);
    chk("div_result",  result,     32'd14);
    chk("div_error",   error_flag, 1'b0);
    release_out();
    accept(4'd10, 32'd100, 32'd7);
    wait_valid(lat, bc);
    chk("rem_result", result, 32'd2);
    release_out();

    // Division by zero completes immediately.
    accept(4'd9, 32'd5, 32'd0);
    wait_valid(lat, bc);
    chk("div0_latency", lat,        1);
    chk("div0_busy",    bc,         0);
    chk("div0_result",  result,     32'hFFFF_FFFF);
    chk("div0_error",   error_flag, 1'b1);
    release_out();
    accept(4'd10, 32'd5, 32'd0);
    wait_valid(lat, bc);
    chk("rem0_result", result,     32'd5);
    chk("rem0_error",  error_flag, 1'b1);
    release_out();

    // Backpressure with a competing request held on the input.
    accept(4'd1, 32'd3, 32'd5);
    wait_valid(lat, bc);
    chk("bp_latency", lat, 1);
    in_valid = 1'b1;
    op_code  = 4'd0;
    a        = 32'd1;
    b        = 32'd1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_in_ready",  in_ready,      1'b0);
      chk("bp_result",    result,        32'hFFFF_FFFE);
      chk("bp_negative",  negative_flag, 1'b1);
      chk("bp_out_valid", out_valid,     1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_in_ready_handshake", in_ready, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1'b1);
    exp_q.push_back(model(4'd0, 32'd1, 32'd1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat, bc);
    chk("bp_next_latency", lat,    1);
    chk("bp_next_result",  result, 32'd2);
    release_out();

    // MULT overflow, invalid op, arithmetic shift using only the low shift bits.
    accept(4'd8, 32'h0001_0000, 32'h0001_0000);
    wait_valid(lat, bc);
    chk("mult_result",   result,        32'd0);
    chk("mult_zero",     zero_flag,     1'b1);
    chk("mult_overflow", overflow_flag, 1'b1);
    release_out();
    accept(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_valid(lat, bc);
    chk("inv_result",   result,        32'd0);
    chk("inv_error",    error_flag,    1'b1);
    chk("inv_overflow", overflow_flag, 1'b0);
    chk("inv_zero",     zero_flag,     1'b1);
    release_out();
    accept(4'd7, 32'h8000_0000, 32'h0000_0021);
    wait_valid(lat, bc);
    chk("sra_result", result, 32'hC000_0000);
    release_out();

    // Further vectors checked through the model only.
    for (int i = 0; i < 8; i++) begin
      accept(tv_op[i], tv_a[i], tv_b[i]);
      wait_valid(lat, bc);
      release_out();
    end

    // Reset in the 10th DIV_RUN cycle aborts the division.
    accept(4'd9, 32'hFFFF_FFFF, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy",      busy,      1'b0);
    chk("abort_result",    result,    32'd0);
    chk("abort_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    accept(4'd0, 32'd2, 32'd3);
    wait_valid(lat, bc);
    chk("post_abort_result", result, 32'd5);
    release_out();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
